// File: rtl/irq_ctrl_if.sv
// Peripheral-bus register port of the interrupt controller: word address,
// single-cycle write strobe, write data and combinational read data.
interface irq_ctrl_if;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: rising-edge capture into PEND, masking, fixed priority (source 0 highest),
// single in-service interrupt cleared by EOI. Optional ack counter at register 4 under `IRQ_CNT_EN.
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  irq_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             ack,
  output logic             irq_out,
  output logic [1:0]       state_dbg
);

  // Handshakes: a bus write happens in every cycle where WE=1 (one word, no stall);
  // ack is a one-cycle pulse that is only honoured in REQ while a masked-in source is pending.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  localparam logic [2:0] A_PEND = 3'd0;
  localparam logic [2:0] A_MASK = 3'd1;
  localparam logic [2:0] A_CUR  = 3'd2;
  localparam logic [2:0] A_EOI  = 3'd3;
  localparam logic [2:0] A_CNT  = 3'd4;

  state_t           state, state_n;
  logic [N_SRC-1:0] pend, pend_n;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] prev;
  logic             cur_valid;
  logic [3:0]       cur_id;

  logic [2:0]       reg_idx;
  logic             wr_pend, wr_mask, wr_eoi;
  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] active;
  logic             any_active;
  logic             ack_take;
  logic             eoi_take;
  logic [3:0]       sel_id;
  logic [N_SRC-1:0] sel_onehot;

  assign reg_idx    = bus.Addr[4:2];
  assign wr_pend    = bus.WE && (reg_idx == A_PEND);
  assign wr_mask    = bus.WE && (reg_idx == A_MASK);
  assign wr_eoi     = bus.WE && (reg_idx == A_EOI);

  assign edges      = irq_src & ~prev;
  assign active     = pend & mask;
  assign any_active = |active;
  assign ack_take   = ack && (state == ST_REQ) && any_active;
  assign eoi_take   = wr_eoi && (state == ST_SERV);

  assign irq_out    = (state == ST_REQ);
  assign state_dbg  = state;

  // Lowest set index of the active vector wins.
  always_comb begin
    sel_id = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) sel_id = 4'(i);
    end
  end

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      sel_onehot[i] = (sel_id == 4'(i));
    end
  end

  // W1C first, then new edges (set wins), then the ack clear overrides both.
  always_comb begin
    pend_n = pend;
    if (wr_pend) pend_n = pend_n & ~bus.Din[N_SRC-1:0];
    pend_n = pend_n | edges;
    if (ack_take) pend_n = pend_n & ~sel_onehot;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (any_active) state_n = ST_REQ;
      ST_REQ: begin
        if (ack_take)        state_n = ST_SERV;
        else if (!any_active) state_n = ST_IDLE;
      end
      ST_SERV: if (eoi_take) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pend      <= '0;
      mask      <= '0;
      prev      <= '0;
      cur_valid <= 1'b0;
      cur_id    <= 4'd0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      prev  <= irq_src;
      if (wr_mask) mask <= bus.Din[N_SRC-1:0];
      if (ack_take) begin
        cur_valid <= 1'b1;
        cur_id    <= sel_id;
      end else if (eoi_take) begin
        cur_valid <= 1'b0;
        cur_id    <= 4'd0;
      end
    end
  end

`ifdef IRQ_CNT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)         cnt <= 32'd0;
    else if (ack_take) cnt <= cnt + 32'd1;
  end
`endif

  always_comb begin
    bus.Dout = 32'd0;
    case (reg_idx)
      A_PEND:  bus.Dout = {{(32 - N_SRC){1'b0}}, pend};
      A_MASK:  bus.Dout = {{(32 - N_SRC){1'b0}}, mask};
      A_CUR:   bus.Dout = {cur_valid, 27'd0, cur_id};
`ifdef IRQ_CNT_EN
      A_CNT:   bus.Dout = cnt;
`endif
      default: bus.Dout = 32'd0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{bus.Addr[31:5], bus.Din[31:N_SRC]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed test-plan steps followed by random traffic, all checked
// against a transaction-level model of pending/mask/in-service behaviour.
module tb_irq_ctrl;

  localparam int N   = 6;
  localparam int ALL = (1 << N) - 1;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_SERV = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_src;
  logic         ack;
  logic         irq_out;
  logic [1:0]   state_dbg;

  irq_ctrl_if bus ();

  irq_ctrl #(.N_SRC(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .irq_src   (irq_src),
    .ack       (ack),
    .irq_out   (irq_out),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pending set, enable set, the one in-service source, and the CPU request phase.
  int          m_pend, m_mask, m_prev, m_phase;
  logic [31:0] m_cur;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_prev = 0; m_phase = P_IDLE;
    m_cur = 32'd0; m_cnt = 32'd0;
  endtask

  task automatic model_step(input logic we, input logic [2:0] a, input logic [31:0] d,
                            input logic [N-1:0] s, input logic k);
    int edges, act, np, sel;
    edges = int'(s) & ~m_prev & ALL;
    act   = m_pend & m_mask;
    np    = m_pend;
    if (we && a == 3'd0) np = np & ~int'(d);
    np = (np | edges) & ALL;
    if (k && m_phase == P_REQ && act != 0) begin
      sel   = $clog2(act & -act);
      np    = np & ~(1 << sel);
      m_cur = 32'h8000_0000 | 32'(sel);
`ifdef IRQ_CNT_EN
      m_cnt = m_cnt + 32'd1;
`endif
      m_phase = P_SERV;
    end else if (m_phase == P_REQ && act == 0) begin
      m_phase = P_IDLE;
    end else if (m_phase == P_IDLE && act != 0) begin
      m_phase = P_REQ;
    end else if (m_phase == P_SERV && we && a == 3'd3) begin
      m_phase = P_IDLE;
      m_cur   = 32'd0;
    end
    if (we && a == 3'd1) m_mask = int'(d) & ALL;
    m_pend = np;
    m_prev = int'(s);
  endtask

  task automatic tick(input logic we, input logic [2:0] a, input logic [31:0] d,
                      input logic [N-1:0] s, input logic k);
    bus.WE   = we;
    bus.Addr = {27'd0, a};
    bus.Din  = d;
    irq_src  = s;
    ack      = k;
    @(posedge clk);
    model_step(we, a, d, s, k);
    #1;
    bus.WE = 1'b0;
    ack    = 1'b0;
    chk("irq_out", {31'd0, irq_out}, {31'd0, m_phase == P_REQ});
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    bus.Addr = {27'd0, a};
    #1;
    chk(tag, bus.Dout, exp);
  endtask

  task automatic chk_model();
    rd(3'd0, 32'(m_pend), "pend_model");
    rd(3'd1, 32'(m_mask), "mask_model");
    rd(3'd2, m_cur, "cur_model");
    rd(3'd4, m_cnt, "reg4_model");
    rd(3'd3, 32'd0, "eoi_reads_zero");
  endtask

  task automatic do_reset(input logic [N-1:0] s);
    reset    = 1'b1;
    bus.WE   = 1'b0;
    bus.Addr = '0;
    bus.Din  = '0;
    ack      = 1'b0;
    irq_src  = s;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    chk("reset_irq_out", {31'd0, irq_out}, 32'd0);
  endtask

  logic [N-1:0] rs;

  initial begin
    model_reset();
    do_reset('0);
    do_reset('0);
    rd(3'd0, 32'd0, "rst_pend");
    rd(3'd1, 32'd0, "rst_mask");
    rd(3'd2, 32'd0, "rst_cur");
    rd(3'd4, 32'd0, "rst_reg4");

    // Single masked-in source: capture, request, ack, EOI.
    tick(1, 3'd1, 32'h01, 6'h00, 0);
    tick(0, 3'd0, 32'h00, 6'h01, 0);
    rd(3'd0, 32'h01, "t1_pend_set");
    chk("t1_irq_low_at_edge", {31'd0, irq_out}, 32'd0);
    tick(0, 3'd0, 32'h00, 6'h01, 0);
    chk("t1_irq_high", {31'd0, irq_out}, 32'd1);
    tick(0, 3'd0, 32'h00, 6'h01, 0);
    tick(0, 3'd0, 32'h00, 6'h01, 1);
    rd(3'd2, 32'h8000_0000, "t1_cur");
    rd(3'd0, 32'h0, "t1_pend_clr");
    chk("t1_irq_serv", {31'd0, irq_out}, 32'd0);
    tick(1, 3'd3, 32'hDEAD_BEEF, 6'h01, 0);
    rd(3'd2, 32'h0, "t1_cur_eoi");
    tick(0, 3'd0, 32'h00, 6'h00, 0);
    chk("t1_idle", {31'd0, irq_out}, 32'd0);
    chk_model();

    // Two simultaneous sources: lower index served first.
    tick(1, 3'd1, 32'h3F, 6'h00, 0);
    tick(0, 3'd0, 32'h00, 6'h0A, 0);
    tick(0, 3'd0, 32'h00, 6'h0A, 0);
    tick(0, 3'd0, 32'h00, 6'h0A, 1);
    rd(3'd2, 32'h8000_0001, "t2_cur_id1");
    rd(3'd0, 32'h08, "t2_pend_left");
    tick(0, 3'd0, 32'h00, 6'h00, 0);
    chk("t2_irq_serv", {31'd0, irq_out}, 32'd0);
    tick(1, 3'd3, 32'h0, 6'h00, 0);
    chk("t2_irq_after_eoi", {31'd0, irq_out}, 32'd0);
    tick(0, 3'd0, 32'h00, 6'h00, 0);
    chk("t2_irq_reassert", {31'd0, irq_out}, 32'd1);
    tick(0, 3'd0, 32'h00, 6'h00, 1);
    rd(3'd2, 32'h8000_0003, "t2_cur_id3");
    tick(1, 3'd3, 32'h0, 6'h00, 0);
    chk_model();

    // Masked pending source, then enable, withdraw and restore.
    tick(1, 3'd1, 32'h00, 6'h00, 0);
    tick(0, 3'd0, 32'h00, 6'h04, 0);
    tick(0, 3'd0, 32'h00, 6'h00, 0);
    rd(3'd0, 32'h04, "t3_pend_masked");
    chk("t3_irq_masked", {31'd0, irq_out}, 32'd0);
    tick(1, 3'd1, 32'h04, 6'h00, 0);
    tick(0, 3'd0, 32'h00, 6'h00, 0);
    chk("t3_irq_unmasked", {31'd0, irq_out}, 32'd1);
    tick(1, 3'd1, 32'h00, 6'h00, 0);
    tick(0, 3'd0, 32'h00, 6'h00, 0);
    chk("t3_withdrawn", {31'd0, irq_out}, 32'd0);
    tick(0, 3'd0, 32'h00, 6'h00, 1);
    rd(3'd2, 32'h0, "t3_ack_ignored_idle");
    tick(1, 3'd1, 32'h04, 6'h00, 0);
    tick(0, 3'd0, 32'h00, 6'h00, 0);
    chk("t3_restored", {31'd0, irq_out}, 32'd1);
    tick(0, 3'd0, 32'h00, 6'h00, 1);
    tick(1, 3'd3, 32'h0, 6'h00, 0);
    chk_model();

    // Same-cycle W1C and edge, then an absorbed second edge.
    tick(1, 3'd1, 32'h02, 6'h00, 0);
    tick(1, 3'd0, 32'h02, 6'h02, 0);
    rd(3'd0, 32'h02, "t4_set_wins");
    tick(0, 3'd0, 32'h00, 6'h00, 0);
    tick(0, 3'd0, 32'h00, 6'h02, 0);
    tick(0, 3'd0, 32'h00, 6'h02, 1);
    rd(3'd0, 32'h00, "t4_one_ack");
    tick(1, 3'd3, 32'h0, 6'h02, 0);
    tick(0, 3'd0, 32'h00, 6'h02, 0);
    chk("t4_no_second", {31'd0, irq_out}, 32'd0);
    chk_model();

    // Reset while in service; source held high through reset counts as one edge.
    tick(0, 3'd0, 32'h00, 6'h00, 0);
    tick(0, 3'd0, 32'h00, 6'h02, 0);
    tick(0, 3'd0, 32'h00, 6'h02, 0);
    tick(0, 3'd0, 32'h00, 6'h02, 1);
    rd(3'd2, 32'h8000_0001, "t5_in_service");
    do_reset(6'h02);
    rd(3'd2, 32'h0, "t5_cur_rst");
    rd(3'd0, 32'h0, "t5_pend_rst");
    rd(3'd1, 32'h0, "t5_mask_rst");
    rd(3'd4, 32'h0, "t5_reg4_rst");
    tick(0, 3'd0, 32'h00, 6'h02, 0);
    rd(3'd0, 32'h02, "t5_held_edge");
    tick(1, 3'd1, 32'h01, 6'h02, 0);
    for (int r = 0; r < 3; r++) begin
      tick(0, 3'd0, 32'h00, 6'h03, 0);
      tick(0, 3'd0, 32'h00, 6'h03, 0);
      tick(0, 3'd0, 32'h00, 6'h03, 1);
      tick(1, 3'd3, 32'h0, 6'h03, 0);
      tick(0, 3'd0, 32'h00, 6'h02, 0);
    end
`ifdef IRQ_CNT_EN
    rd(3'd4, 32'd3, "t5_cnt3");
`else
    rd(3'd4, 32'd0, "t5_reg4_absent");
`endif
    tick(1, 3'd4, 32'hFFFF_FFFF, 6'h02, 0);
    chk_model();

    // Random traffic against the model.
    rs = '0;
    for (int c = 0; c < 800; c++) begin
      logic       we;
      logic [2:0] a;
      if ($urandom_range(0, 2) == 0) rs = N'($urandom);
      we = ($urandom_range(0, 3) == 0);
      a  = 3'($urandom_range(0, 7));
      if (c == 400) do_reset(rs);
      else tick(we, a, $urandom, rs, ($urandom_range(0, 2) == 0));
      chk_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
